// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the read-side FIFO drain engine.
// Burst position states, skid buffer depth, and beat-index width helper.
package fifo_rd_pkg;

   localparam int SKID_DEPTH = 2;
   localparam int CNT_W      = 2;

   typedef enum logic [1:0] {
      FIRST = 2'd0,
      MID   = 2'd1,
      LAST  = 2'd2
   } burst_state_t;

   // A one-beat burst still needs a 1-bit index port.
   function automatic int beat_width(input int burst_len);
      return (burst_len > 1) ? $clog2(burst_len) : 1;
   endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry head/tail skid buffer absorbing the FIFO's registered read latency.
// Write lands in the first free slot; read shifts tail to head; clear empties it next cycle.
module fifo_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clr,
   input  logic                  i_wr,
   input  logic [DATA_WIDTH-1:0] i_wr_dat,
   input  logic                  i_rd,
   output logic [DATA_WIDTH-1:0] o_head_dat,
   output logic [CNT_W-1:0]      o_count
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SKID_DEPTH);

   logic [DATA_WIDTH-1:0] r_head;
   logic [DATA_WIDTH-1:0] r_tail;
   logic [CNT_W-1:0]      r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else begin
         case ({i_wr, i_rd})
            2'b10: begin
               if (r_count == '0) r_head <= i_wr_dat;
               else               r_tail <= i_wr_dat;
               r_count <= r_count + CNT_ONE;
            end
            2'b01: begin
               r_head  <= r_tail;
               r_count <= r_count - CNT_ONE;
            end
            2'b11: begin
               // Occupancy is unchanged; the new word joins behind whatever remains.
               if (r_count == CNT_ONE) begin
                  r_head <= i_wr_dat;
               end else begin
                  r_head <= r_tail;
                  r_tail <= i_wr_dat;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_head_dat = r_head;
   assign o_count    = r_count;

   a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst || i_clr)
      !(i_wr && !i_rd && (r_count == CNT_FULL)));

   a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst || i_clr)
      !(i_rd && (r_count == '0)));

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains the dual-clock FIFO read port into a valid/ready stream grouped into bursts.
// Word reaches m_valid two cycles after fifo_ren; backpressure stalls issue once buffer+inflight reach two.
module fifo_rd_streamer
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4,
   parameter int BEAT_W     = beat_width(BURST_LEN)
) (
   input  logic                  rclk,
   input  logic                  rrst,
   input  logic                  flush,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  fifo_ren,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [BEAT_W-1:0]     m_beat
);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   localparam burst_state_t      START_ST  = (BURST_LEN == 1) ? LAST : FIRST;

   logic                  r_inflight;
   logic [CNT_W-1:0]      w_count;
   logic [DATA_WIDTH-1:0] w_head_dat;
   logic                  w_pop;
   logic                  w_wr;
   logic                  w_rd;
   logic [CNT_W-1:0]      w_occ_after;

   burst_state_t          r_state;
   burst_state_t          w_state_nxt;
   logic [BEAT_W-1:0]     r_beat;
   logic [BEAT_W-1:0]     w_beat_nxt;
   logic [BEAT_W-1:0]     w_beat_inc;

   assign m_valid = (w_count != '0);
   assign w_pop   = m_valid & m_ready;
   assign w_wr    = r_inflight & ~flush & ~rrst;
   assign w_rd    = w_pop & ~flush & ~rrst;

   // Occupancy once this cycle's pop retires; issuing only at <=1 keeps a slot for every arrival.
   assign w_occ_after = w_count + CNT_W'(r_inflight) - CNT_W'(w_pop);
   assign fifo_ren    = ~fifo_empty & ~flush & ~rrst & (w_occ_after <= CNT_W'(1));

   always_ff @(posedge rclk) begin
      if (rrst) r_inflight <= 1'b0;
      else      r_inflight <= fifo_ren;
   end

   fifo_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .i_clk      (rclk),
      .i_rst      (rrst),
      .i_clr      (flush),
      .i_wr       (w_wr),
      .i_wr_dat   (fifo_rdata),
      .i_rd       (w_rd),
      .o_head_dat (w_head_dat),
      .o_count    (w_count)
   );

   always_ff @(posedge rclk) begin
      if (rrst || flush) begin
         r_state <= START_ST;
         r_beat  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
      end
   end

   assign w_beat_inc = r_beat + BEAT_W'(1);

   // Wrap happens from LAST, so non-power-of-two burst lengths count modulo BURST_LEN.
   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      if (w_pop) begin
         case (r_state)
            LAST: begin
               w_state_nxt = START_ST;
               w_beat_nxt  = '0;
            end
            default: begin
               w_beat_nxt  = w_beat_inc;
               w_state_nxt = (w_beat_inc == LAST_BEAT) ? LAST : MID;
            end
         endcase
      end
   end

   assign m_data = w_head_dat;
   assign m_beat = r_beat;
   assign m_last = m_valid & (r_beat == LAST_BEAT);

   a_hold_stable: assert property (@(posedge rclk) disable iff (rrst || flush)
      (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_beat)));

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: queue-based FIFO and occupancy/beat reference model,
// directed scenarios plus randomized ready/empty/flush/reset traffic on BURST_LEN 4 and 1 builds.
module tb_fifo_rd_streamer;

   localparam int BL = 4;

   logic       rclk = 1'b0;
   logic       rrst;
   logic       flush;
   logic       fifo_empty;
   logic [7:0] fifo_rdata;
   logic       m_ready;

   logic       fifo_ren, m_valid, m_last;
   logic [7:0] m_data;
   logic [1:0] m_beat;

   logic       fifo_ren1, m_valid1, m_last1;
   logic [7:0] m_data1;
   logic [0:0] m_beat1;

   fifo_rd_streamer #(.DATA_WIDTH(8), .BURST_LEN(BL)) dut (
      .rclk(rclk), .rrst(rrst), .flush(flush), .fifo_empty(fifo_empty),
      .fifo_rdata(fifo_rdata), .fifo_ren(fifo_ren), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_beat(m_beat));

   fifo_rd_streamer #(.DATA_WIDTH(8), .BURST_LEN(1)) dut1 (
      .rclk(rclk), .rrst(rrst), .flush(flush), .fifo_empty(fifo_empty),
      .fifo_rdata(fifo_rdata), .fifo_ren(fifo_ren1), .m_valid(m_valid1),
      .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1), .m_beat(m_beat1));

   always #5 rclk = ~rclk;

   int checks = 0;
   int errors = 0;

   logic [7:0] fifo_q[$];
   logic [7:0] buf_q[$];
   logic [7:0] out_q[$];
   logic [1:0] out_beat_q[$];
   bit         infl = 1'b0;
   int         pops = 0;
   logic [7:0] seq  = 8'h00;

   logic       o_ren, o_vld, o_last;
   logic [7:0] o_dat;
   logic [1:0] o_beat;
   logic       o1_ren, o1_vld, o1_last;
   logic [7:0] o1_dat;
   logic [0:0] o1_beat;
   logic       e_ren, e_vld, e_last;
   logic [7:0] e_dat;
   logic [1:0] e_beat;

   task automatic push_words(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) fifo_q.push_back(8'(base + i));
   endtask

   // One read-clock cycle: drive inputs, sample mid-cycle, advance the reference model.
   task automatic step(input bit rdy, input bit fl, input bit gap, input bit rst);
      bit         pop;
      int         occ;
      logic [7:0] tmp;
      rrst       = rst;
      m_ready    = rdy;
      flush      = fl;
      fifo_empty = gap || (fifo_q.size() == 0);
      @(negedge rclk);
      o_ren  = fifo_ren;  o_vld  = m_valid;  o_dat  = m_data;  o_last  = m_last;  o_beat  = m_beat;
      o1_ren = fifo_ren1; o1_vld = m_valid1; o1_dat = m_data1; o1_last = m_last1; o1_beat = m_beat1;
      e_vld  = (buf_q.size() != 0);
      e_dat  = e_vld ? buf_q[0] : 8'h00;
      e_beat = 2'(pops % BL);
      e_last = e_vld && (pops % BL == BL - 1);
      pop    = e_vld && rdy;
      occ    = buf_q.size() + int'(infl) - int'(pop);
      e_ren  = !fifo_empty && !fl && !rst && (occ <= 1);
      if (o_vld === 1'b1 && rdy && !fl && !rst) begin
         out_q.push_back(o_dat);
         out_beat_q.push_back(o_beat);
      end
      if (fl || rst) begin
         buf_q.delete();
         pops = 0;
      end else begin
         if (pop) begin
            tmp  = buf_q.pop_front();
            pops = pops + 1;
         end
         if (infl) buf_q.push_back(fifo_rdata);
      end
      infl = (o_ren === 1'b1);
      @(posedge rclk);
      #1;
      if (o_ren === 1'b1 && fifo_q.size() != 0) fifo_rdata = fifo_q.pop_front();
   endtask

   task automatic test_reset();
      fifo_q.delete();
      push_words(8, 8'h10);
      for (int c = 0; c < 3; c++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         checks++; if (o_ren !== 1'b0)  begin errors++; $display("FAIL reset_ren c=%0d got=%b exp=0", c, o_ren); end
         checks++; if (o_vld !== 1'b0)  begin errors++; $display("FAIL reset_vld c=%0d got=%b exp=0", c, o_vld); end
         checks++; if (o_beat !== 2'd0) begin errors++; $display("FAIL reset_beat c=%0d got=%0d exp=0", c, o_beat); end
         checks++; if (o_dat !== 8'h00) begin errors++; $display("FAIL reset_data c=%0d got=%h exp=00", c, o_dat); end
         checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL reset_last c=%0d got=%b exp=0", c, o_last); end
      end
   endtask

   task automatic test_streaming();
      logic       want_ren, want_vld, want_last;
      logic [7:0] want_d;
      logic [1:0] want_b;
      out_q.delete(); out_beat_q.delete();
      for (int c = 0; c < 12; c++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         want_ren = (c < 8);
         want_vld = (c >= 2) && (c <= 9);
         checks++; if (o_ren !== want_ren) begin errors++; $display("FAIL stream_ren c=%0d got=%b exp=%b", c, o_ren, want_ren); end
         checks++; if (o_vld !== want_vld) begin errors++; $display("FAIL stream_vld c=%0d got=%b exp=%b", c, o_vld, want_vld); end
         if (want_vld) begin
            want_d    = 8'(8'h10 + c - 2);
            want_b    = 2'((c - 2) % 4);
            want_last = ((c - 2) % 4 == 3);
            checks++; if (o_dat !== want_d)     begin errors++; $display("FAIL stream_data c=%0d got=%h exp=%h", c, o_dat, want_d); end
            checks++; if (o_beat !== want_b)    begin errors++; $display("FAIL stream_beat c=%0d got=%0d exp=%0d", c, o_beat, want_b); end
            checks++; if (o_last !== want_last) begin errors++; $display("FAIL stream_last c=%0d got=%b exp=%b", c, o_last, want_last); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] h_dat;
      logic [1:0] h_beat;
      logic       h_last;
      int         nren;
      nren = 0;
      out_q.delete(); out_beat_q.delete();
      push_words(12, 8'h40);
      for (int c = 0; c < 6; c++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         checks++; if (o_ren !== e_ren) begin errors++; $display("FAIL bp_ren c=%0d got=%b exp=%b", c, o_ren, e_ren); end
         checks++; if (o_vld !== e_vld) begin errors++; $display("FAIL bp_vld c=%0d got=%b exp=%b", c, o_vld, e_vld); end
      end
      for (int c = 0; c < 5; c++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         if (c == 0) begin h_dat = e_dat; h_beat = e_beat; h_last = e_last; end
         if (o_ren === 1'b1) nren++;
         checks++; if (o_vld !== 1'b1)   begin errors++; $display("FAIL bp_hold_vld c=%0d got=%b exp=1", c, o_vld); end
         checks++; if (o_dat !== h_dat)  begin errors++; $display("FAIL bp_hold_data c=%0d got=%h exp=%h", c, o_dat, h_dat); end
         checks++; if (o_beat !== h_beat) begin errors++; $display("FAIL bp_hold_beat c=%0d got=%0d exp=%0d", c, o_beat, h_beat); end
         checks++; if (o_last !== h_last) begin errors++; $display("FAIL bp_hold_last c=%0d got=%b exp=%b", c, o_last, h_last); end
         checks++; if (o_ren !== e_ren)  begin errors++; $display("FAIL bp_hold_ren c=%0d got=%b exp=%b", c, o_ren, e_ren); end
      end
      checks++; if (nren > 2) begin errors++; $display("FAIL bp_issue_count got=%0d exp<=2", nren); end
      for (int c = 0; c < 25; c++) step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (out_q.size() != 12) begin errors++; $display("FAIL bp_word_count got=%0d exp=12", out_q.size()); end
      for (int i = 0; i < 12 && i < out_q.size(); i++) begin
         checks++; if (out_q[i] !== 8'(8'h40 + i)) begin errors++; $display("FAIL bp_order i=%0d got=%h exp=%h", i, out_q[i], 8'(8'h40 + i)); end
      end
   endtask

   task automatic test_empty_gap();
      int start;
      start = pops % BL;
      out_q.delete(); out_beat_q.delete();
      push_words(3, 8'h60);
      for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 1'b0, 1'b0);
      push_words(3, 8'h63);
      for (int c = 0; c < 4; c++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0);
         checks++; if (o_ren !== 1'b0) begin errors++; $display("FAIL gap_ren c=%0d got=%b exp=0", c, o_ren); end
         checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL gap_vld c=%0d got=%b exp=0", c, o_vld); end
      end
      for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (out_q.size() != 6) begin errors++; $display("FAIL gap_word_count got=%0d exp=6", out_q.size()); end
      for (int i = 0; i < 6 && i < out_q.size(); i++) begin
         checks++; if (out_q[i] !== 8'(8'h60 + i)) begin errors++; $display("FAIL gap_order i=%0d got=%h exp=%h", i, out_q[i], 8'(8'h60 + i)); end
         checks++; if (out_beat_q[i] !== 2'((start + i) % BL)) begin errors++; $display("FAIL gap_beat i=%0d got=%0d exp=%0d", i, out_beat_q[i], (start + i) % BL); end
      end
   endtask

   task automatic test_flush_inflight();
      logic [7:0] dropped;
      logic [7:0] rest[$];
      out_q.delete(); out_beat_q.delete();
      push_words(10, 8'h80);
      for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (o_ren !== 1'b1) begin errors++; $display("FAIL flush_pre_ren got=%b exp=1", o_ren); end
      dropped = fifo_rdata;
      step(1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (o_ren !== 1'b0) begin errors++; $display("FAIL flush_ren got=%b exp=0", o_ren); end
      rest = fifo_q;
      out_q.delete(); out_beat_q.delete();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL flush_vld got=%b exp=0", o_vld); end
      for (int c = 0; c < 20; c++) step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (out_q.size() != rest.size()) begin errors++; $display("FAIL flush_word_count got=%0d exp=%0d", out_q.size(), rest.size()); end
      for (int i = 0; i < rest.size() && i < out_q.size(); i++) begin
         checks++; if (out_q[i] !== rest[i]) begin errors++; $display("FAIL flush_order i=%0d got=%h exp=%h", i, out_q[i], rest[i]); end
         checks++; if (out_q[i] === dropped) begin errors++; $display("FAIL flush_dropped_seen i=%0d got=%h exp=not %h", i, out_q[i], dropped); end
      end
      if (out_beat_q.size() != 0) begin
         checks++; if (out_beat_q[0] !== 2'd0) begin errors++; $display("FAIL flush_first_beat got=%0d exp=0", out_beat_q[0]); end
      end
   endtask

   task automatic test_burst_len1();
      int acc;
      bit rdy;
      acc = 0;
      push_words(4, 8'hA0);
      for (int c = 0; c < 36; c++) begin
         rdy = (c >= 30) || ($urandom_range(0, 3) != 0);
         step(rdy, 1'b0, 1'b0, 1'b0);
         checks++; if (o1_ren !== e_ren) begin errors++; $display("FAIL bl1_ren c=%0d got=%b exp=%b", c, o1_ren, e_ren); end
         checks++; if (o1_vld !== e_vld) begin errors++; $display("FAIL bl1_vld c=%0d got=%b exp=%b", c, o1_vld, e_vld); end
         if (e_vld) begin
            checks++; if (o1_last !== 1'b1) begin errors++; $display("FAIL bl1_last c=%0d got=%b exp=1", c, o1_last); end
            checks++; if (o1_beat !== 1'b0) begin errors++; $display("FAIL bl1_beat c=%0d got=%0d exp=0", c, o1_beat); end
            checks++; if (o1_dat !== e_dat) begin errors++; $display("FAIL bl1_data c=%0d got=%h exp=%h", c, o1_dat, e_dat); end
            if (rdy) acc++;
         end
      end
      checks++; if (acc != 4) begin errors++; $display("FAIL bl1_beats got=%0d exp=4", acc); end
   endtask

   task automatic test_random();
      bit rdy, gap, fl, rst;
      for (int c = 0; c < 600; c++) begin
         rdy = ($urandom_range(0, 3) != 0);
         gap = ($urandom_range(0, 5) == 0);
         fl  = ($urandom_range(0, 40) == 0);
         rst = ($urandom_range(0, 150) == 0);
         if (fifo_q.size() < 4 && $urandom_range(0, 1) == 1) begin
            fifo_q.push_back(seq);
            seq = seq + 8'd1;
         end
         step(rdy, fl, gap, rst);
         checks++; if (o_ren !== e_ren)   begin errors++; $display("FAIL rnd_ren c=%0d got=%b exp=%b", c, o_ren, e_ren); end
         checks++; if (o_vld !== e_vld)   begin errors++; $display("FAIL rnd_vld c=%0d got=%b exp=%b", c, o_vld, e_vld); end
         checks++; if (o_beat !== e_beat) begin errors++; $display("FAIL rnd_beat c=%0d got=%0d exp=%0d", c, o_beat, e_beat); end
         checks++; if (o_last !== e_last) begin errors++; $display("FAIL rnd_last c=%0d got=%b exp=%b", c, o_last, e_last); end
         checks++; if (o1_last !== e_vld) begin errors++; $display("FAIL rnd_bl1_last c=%0d got=%b exp=%b", c, o1_last, e_vld); end
         if (e_vld) begin
            checks++; if (o_dat !== e_dat) begin errors++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, o_dat, e_dat); end
         end
      end
   endtask

   initial begin
      rrst       = 1'b1;
      flush      = 1'b0;
      fifo_empty = 1'b1;
      fifo_rdata = 8'h00;
      m_ready    = 1'b0;
      @(posedge rclk);
      #1;
      test_reset();
      test_streaming();
      test_backpressure();
      test_empty_gap();
      test_flush_inflight();
      test_burst_len1();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
